// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage with a one-entry data-SRAM response buffer and load extension.
// Optional ID bypass outputs are enabled by defining MS_BYPASS_EN (tied to zero otherwise).
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_alu_result,
  input  logic        es_mem_req,
  input  logic [4:0]  es_load_op,
  input  logic [4:0]  es_rf_waddr,
  input  logic        es_rf_we,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_rf_wdata,
  output logic [4:0]  ms_rf_waddr,
  output logic        ms_rf_we,
  output logic        ms_fwd_we,
  output logic [4:0]  ms_fwd_waddr,
  output logic [31:0] ms_fwd_wdata,
  output logic        ms_fwd_blk
);
  // State bits are {wait_ok, buf_valid}.
  typedef enum logic [1:0] {WAIT_NONE = 2'b00, WAIT_OK = 2'b10, HELD = 2'b11} wait_e;

  wait_e       state, state_nxt;
  logic        ms_valid, wait_ok, buf_valid, ms_ready_go, ms_capture, buf_fill;
  logic [31:0] alu_result, buf_data, rdata, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  load_op;

  assign wait_ok        = state[1];
  assign buf_valid      = state[0];
  assign ms_ready_go    = !ms_valid || !wait_ok || data_sram_data_ok || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_capture     = es_to_ms_valid && ms_allowin;
  assign buf_fill       = ms_valid && wait_ok && !buf_valid && data_sram_data_ok && !ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_NONE;
    else       state <= state_nxt;
  end

  // A capture overrides the exit transition: the new instruction's wait_ok comes from es_mem_req.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_OK:   if (ms_valid && data_sram_data_ok) state_nxt = ws_allowin ? WAIT_NONE : HELD;
      HELD:      if (ws_allowin) state_nxt = WAIT_NONE;
      WAIT_NONE: state_nxt = WAIT_NONE;
      default:   state_nxt = WAIT_NONE;
    endcase
    if (ms_capture) state_nxt = es_mem_req ? WAIT_OK : WAIT_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      ms_pc       <= 32'h0;
      alu_result  <= 32'h0;
      load_op     <= 5'h0;
      ms_rf_waddr <= 5'h0;
      ms_rf_we    <= 1'b0;
      buf_data    <= 32'h0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_capture) begin
        ms_pc       <= es_pc;
        alu_result  <= es_alu_result;
        load_op     <= es_load_op;
        ms_rf_waddr <= es_rf_waddr;
        ms_rf_we    <= es_rf_we;
      end
      if (buf_fill) buf_data <= data_sram_rdata;
    end
  end

  assign rdata    = buf_valid ? buf_data : data_sram_rdata;
  assign byte_sel = rdata[{alu_result[1:0], 3'b000} +: 8];
  assign half_sel = alu_result[1] ? rdata[31:16] : rdata[15:0];

  // load_op is one-hot {ld.w, ld.hu, ld.h, ld.bu, ld.b}.
  always_comb begin
    load_data = rdata;
    if (load_op[0])      load_data = {{24{byte_sel[7]}}, byte_sel};
    else if (load_op[1]) load_data = {24'h0, byte_sel};
    else if (load_op[2]) load_data = {{16{half_sel[15]}}, half_sel};
    else if (load_op[3]) load_data = {16'h0, half_sel};
  end

  assign ms_rf_wdata = (load_op != 5'h0) ? load_data : alu_result;

`ifdef MS_BYPASS_EN
  assign ms_fwd_we    = ms_valid && ms_rf_we;
  assign ms_fwd_waddr = ms_rf_waddr;
  assign ms_fwd_wdata = ms_rf_wdata;
  assign ms_fwd_blk   = ms_valid && ms_rf_we && (load_op != 5'h0) && !ms_ready_go;
`else
  assign ms_fwd_we    = 1'b0;
  assign ms_fwd_waddr = 5'h0;
  assign ms_fwd_wdata = 32'h0;
  assign ms_fwd_blk   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: load-extension vector table, directed corner sequences,
// and randomized traffic against a behavioural stage model.
module tb_mem_stage;
`ifdef MS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0, reset;
  logic        ms_allowin, es_to_ms_valid, es_mem_req, es_rf_we, data_sram_data_ok, ws_allowin;
  logic [31:0] es_pc, es_alu_result, data_sram_rdata;
  logic [4:0]  es_load_op, es_rf_waddr;
  logic        ms_to_ws_valid, ms_rf_we, ms_fwd_we, ms_fwd_blk;
  logic [31:0] ms_pc, ms_rf_wdata, ms_fwd_wdata;
  logic [4:0]  ms_rf_waddr, ms_fwd_waddr;

  int total = 0, bad = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_mem_req(es_mem_req),
    .es_load_op(es_load_op), .es_rf_waddr(es_rf_waddr), .es_rf_we(es_rf_we),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_rf_wdata(ms_rf_wdata), .ms_rf_waddr(ms_rf_waddr), .ms_rf_we(ms_rf_we),
    .ms_fwd_we(ms_fwd_we), .ms_fwd_waddr(ms_fwd_waddr), .ms_fwd_wdata(ms_fwd_wdata),
    .ms_fwd_blk(ms_fwd_blk)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_ms_valid = 1'b0; es_pc = 32'h0; es_alu_result = 32'h0; es_mem_req = 1'b0;
    es_load_op = 5'h0; es_rf_waddr = 5'h0; es_rf_we = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; ws_allowin = 1'b1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] op,
                       input logic req, input logic [4:0] waddr, input logic we);
    es_to_ms_valid = 1'b1; es_pc = pc; es_alu_result = alu; es_load_op = op;
    es_mem_req = req; es_rf_waddr = waddr; es_rf_we = we;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Expected write data from the load rules, in plain arithmetic; kind 0 is a non-load.
  function automatic logic [31:0] expect_wdata(int kind, logic [31:0] addr, logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * addr[1:0])) & 32'hFF;
    h = (d >> (16 * addr[1])) & 32'hFFFF;
    case (kind)
      1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      2: return b;
      3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return h;
      5: return d;
      default: return addr;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];

  // Behavioural model of the single stage slot.
  logic        m_valid, m_pend, m_got, m_we;
  logic [31:0] m_pc, m_addr, m_data;
  logic [4:0]  m_dest;
  int          m_kind;

  initial begin
    vt[0]  = '{5'b00001, 32'h1c000002, 32'h0080FF00, 32'hFFFFFF80};
    vt[1]  = '{5'b00010, 32'h1c000002, 32'h0080FF00, 32'h00000080};
    vt[2]  = '{5'b00001, 32'h1c000001, 32'h0080FF00, 32'hFFFFFFFF};
    vt[3]  = '{5'b00010, 32'h00000003, 32'h7F000000, 32'h0000007F};
    vt[4]  = '{5'b00001, 32'h00000000, 32'h1234567F, 32'h0000007F};
    vt[5]  = '{5'b01000, 32'h00000002, 32'hBEEF1234, 32'h0000BEEF};
    vt[6]  = '{5'b00100, 32'h00000002, 32'hBEEF1234, 32'hFFFFBEEF};
    vt[7]  = '{5'b00100, 32'h00000000, 32'hBEEF1234, 32'h00001234};
    vt[8]  = '{5'b01000, 32'h00000000, 32'h00008001, 32'h00008001};
    vt[9]  = '{5'b00100, 32'h00000000, 32'h00008001, 32'hFFFF8001};
    vt[10] = '{5'b10000, 32'h00000004, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[11] = '{5'b00000, 32'h00001234, 32'hFFFFFFFF, 32'h00001234};

    do_reset();
    check("rst_to_ws_valid", ms_to_ws_valid, 0);
    check("rst_allowin", ms_allowin, 1);
    check("rst_fwd_we", ms_fwd_we, 0);
    check("rst_fwd_blk", ms_fwd_blk, 0);
    check("rst_rf_we", ms_rf_we, 0);
    check("rst_pc", ms_pc, 0);

    // ALU op, one-cycle latency
    offer(32'h1c000000, 32'h1234, 5'h0, 1'b0, 5'd5, 1'b1);
    tick();
    es_to_ms_valid = 1'b0; #1;
    check("alu_valid", ms_to_ws_valid, 1);
    check("alu_wdata", ms_rf_wdata, 32'h1234);
    check("alu_pc", ms_pc, 32'h1c000000);
    check("alu_waddr", ms_rf_waddr, 5);
    check("alu_fwd_we", ms_fwd_we, BYP ? 1 : 0);
    check("alu_fwd_wdata", ms_fwd_wdata, BYP ? 32'h1234 : 0);
    tick();
    check("alu_retired", ms_to_ws_valid, 0);

    // ld.b with data_ok two cycles late
    offer(32'h1c000004, 32'h1c000002, 5'b00001, 1'b1, 5'd7, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("ldb_wait_valid", ms_to_ws_valid, 0);
      check("ldb_wait_allowin", ms_allowin, 0);
      check("ldb_wait_blk", ms_fwd_blk, BYP ? 1 : 0);
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0080FF00; #1;
    check("ldb_valid", ms_to_ws_valid, 1);
    check("ldb_wdata", ms_rf_wdata, 32'hFFFFFF80);
    check("ldb_blk_off", ms_fwd_blk, 0);
    tick();
    data_sram_data_ok = 1'b0; #1;
    check("ldb_retired", ms_to_ws_valid, 0);

    // Buffer fill while WB stalls for 3 cycles
    offer(32'h1c000008, 32'h100, 5'b10000, 1'b1, 5'd9, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hA5A5A5A5; ws_allowin = 1'b0; #1;
    check("buf_valid0", ms_to_ws_valid, 1);
    check("buf_wdata0", ms_rf_wdata, 32'hA5A5A5A5);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h11111111;
    for (int i = 1; i < 3; i++) begin
      #1;
      check("buf_hold_valid", ms_to_ws_valid, 1);
      check("buf_hold_wdata", ms_rf_wdata, 32'hA5A5A5A5);
      check("buf_hold_allowin", ms_allowin, 0);
      tick();
    end
    ws_allowin = 1'b1; #1;
    check("buf_accept_valid", ms_to_ws_valid, 1);
    check("buf_accept_wdata", ms_rf_wdata, 32'hA5A5A5A5);
    tick();
    check("buf_once", ms_to_ws_valid, 0);

    // Back-to-back: load completes in the same cycle an ALU op is captured
    offer(32'h1c00000c, 32'h200, 5'b10000, 1'b1, 5'd10, 1'b1);
    tick();
    es_to_ms_valid = 1'b0; #1;
    check("buf_cleared", ms_to_ws_valid, 0);
    tick();
    offer(32'h1c000010, 32'h55AA, 5'h0, 1'b0, 5'd11, 1'b1);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D; #1;
    check("b2b_ld_valid", ms_to_ws_valid, 1);
    check("b2b_ld_wdata", ms_rf_wdata, 32'hCAFEF00D);
    check("b2b_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; #1;
    check("b2b_alu_valid", ms_to_ws_valid, 1);
    check("b2b_alu_wdata", ms_rf_wdata, 32'h55AA);
    check("b2b_alu_pc", ms_pc, 32'h1c000010);
    tick();
    check("b2b_done", ms_to_ws_valid, 0);

    // Reset mid-wait, then a stale data_ok
    offer(32'h1c000014, 32'h300, 5'b10000, 1'b1, 5'd12, 1'b1);
    tick();
    es_to_ms_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h99; ws_allowin = 1'b0; #1;
    check("rstw_valid", ms_to_ws_valid, 0);
    check("rstw_allowin", ms_allowin, 1);
    tick();
    data_sram_data_ok = 1'b0; ws_allowin = 1'b1; #1;
    check("rstw_valid2", ms_to_ws_valid, 0);
    offer(32'h1c000018, 32'h304, 5'b10000, 1'b1, 5'd13, 1'b1);
    tick();
    es_to_ms_valid = 1'b0; #1;
    check("rstw_no_buf", ms_to_ws_valid, 0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BADF00D; #1;
    check("rstw_drain_wdata", ms_rf_wdata, 32'h0BADF00D);
    tick();
    idle();

    // Load-extension vector table
    do_reset();
    for (int i = 0; i < 12; i++) begin
      offer(32'h1c001000 + 4 * i, vt[i].addr, vt[i].op, vt[i].op != 5'h0, 5'(i + 1), 1'b1);
      data_sram_data_ok = 1'b0;
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1; data_sram_rdata = vt[i].rdata; #1;
      check($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1);
      check($sformatf("vec%0d_wdata", i), ms_rf_wdata, vt[i].exp);
      tick();
    end

    // Randomized traffic against the model
    do_reset();
    m_valid = 0; m_pend = 0; m_got = 0; m_we = 0; m_pc = 0; m_addr = 0; m_data = 0;
    m_dest = 0; m_kind = 0;
    for (int c = 0; c < 4000; c++) begin
      int          kind;
      logic        rst, ev, wa, dok, ready, tows, alw;
      logic [31:0] rd, d, ew;
      rst  = ($urandom_range(0, 99) == 0);
      ev   = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 5);
      wa   = ($urandom_range(0, 2) != 0);
      dok  = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      rd   = $urandom;
      reset = rst; es_to_ms_valid = ev; es_pc = $urandom; es_alu_result = $urandom;
      es_load_op = (kind == 0) ? 5'h0 : 5'(1 << (kind - 1));
      es_mem_req = (kind != 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      es_rf_waddr = 5'($urandom_range(0, 31)); es_rf_we = 1'($urandom_range(0, 1));
      ws_allowin = wa; data_sram_data_ok = dok; data_sram_rdata = rd;
      #1;
      ready = !m_valid || !m_pend || dok;
      d     = m_got ? m_data : rd;
      ew    = expect_wdata(m_kind, m_addr, d);
      tows  = m_valid && ready;
      alw   = !m_valid || (ready && wa);
      check("rnd_to_ws_valid", ms_to_ws_valid, tows);
      check("rnd_allowin", ms_allowin, alw);
      check("rnd_fwd_we", ms_fwd_we, BYP && m_valid && m_we);
      check("rnd_fwd_blk", ms_fwd_blk, BYP && m_valid && m_we && m_kind != 0 && !ready);
      if (tows) begin
        check("rnd_pc", ms_pc, m_pc);
        check("rnd_wdata", ms_rf_wdata, ew);
        check("rnd_waddr", ms_rf_waddr, m_dest);
        check("rnd_we", ms_rf_we, m_we);
      end
      if (m_valid && m_we) begin
        check("rnd_fwd_waddr", ms_fwd_waddr, BYP ? m_dest : 5'h0);
        check("rnd_fwd_wdata", ms_fwd_wdata, BYP ? ew : 32'h0);
      end
      if (rst) begin
        m_valid = 0; m_pend = 0; m_got = 0; m_we = 0; m_pc = 0; m_addr = 0; m_dest = 0; m_kind = 0;
      end else if (alw) begin
        m_valid = ev; m_got = 0;
        m_pend = ev && es_mem_req;
        if (ev) begin
          m_pc = es_pc; m_addr = es_alu_result; m_kind = kind; m_dest = es_rf_waddr; m_we = es_rf_we;
        end
      end else if (m_pend && dok) begin
        m_pend = 0; m_got = 1; m_data = rd;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-003 Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: synchronous active-high reset.
- `ms_allowin` out 1: stage can accept from EX this cycle.
- `es_to_ms_valid` in 1: EX offers an instruction.
- `es_pc` in 32: instruction PC.
- `es_alu_result` in 32: ALU result, or memory address when a memory access.
- `es_mem_req` in 1: instruction issued a data-SRAM request that is still awaiting data_ok.
- `es_load_op` in 5: one-hot load type {ld.w, ld.hu, ld.h, ld.bu, ld.b}; zero means not a load.
- `es_rf_waddr` in 5 / `es_rf_we` in 1: destination register and write enable.
- `data_sram_data_ok` in 1: data-SRAM response valid.
- `data_sram_rdata` in 32: response data, valid with data_ok.
- `ws_allowin` in 1: WB can accept.
- `ms_to_ws_valid` out 1: result offered to WB.
- `ms_pc` out 32; `ms_rf_wdata` out 32; `ms_rf_waddr` out 5; `ms_rf_we` out 1: payload to WB.
- `ms_fwd_we` out 1; `ms_fwd_waddr` out 5; `ms_fwd_wdata` out 32: bypass to ID.
- `ms_fwd_blk` out 1: ID must stall; result is not yet available.

Function
REQ-004 Stage register: ms_valid, ms_pc, alu_result, load_op, rf_waddr, rf_we, and a wait_ok flag are captured when `es_to_ms_valid && ms_allowin`; wait_ok is loaded from `es_mem_req`.
REQ-005 Valid update: when `ms_allowin` is high, ms_valid is loaded from `es_to_ms_valid`.
REQ-006 Handshake: `ms_ready_go = !ms_valid || !wait_ok || data_ok || buf_valid`; `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`; `ms_to_ws_valid = ms_valid && ms_ready_go`.
REQ-007 Response buffer: a one-entry rdata buffer (buf_valid, buf_data).
- Fills when `data_ok` arrives while `ms_valid && wait_ok && !buf_valid && !ws_allowin`.
- Clears when the instruction leaves the stage (`ms_to_ws_valid && ws_allowin`).
REQ-008 Read-data source: `buf_data` when buf_valid, else `data_sram_rdata`.
REQ-009 Load alignment and extension, selected by alu_result[1:0]:
- ld.b / ld.bu select byte [8*a+7 : 8*a], then sign- or zero-extend.
- ld.h / ld.hu select halfword by addr[1].
- ld.w passes all 32 bits.
REQ-010 Write-data mux: `ms_rf_wdata` = extended load data if load_op != 0, else alu_result.
REQ-011 State machine: WAIT_NONE / WAIT_OK / HELD, encoded by (wait_ok, buf_valid).
- WAIT_OK -> HELD on data_ok && !ws_allowin.
- WAIT_OK -> exit on data_ok && ws_allowin.
- HELD -> exit on ws_allowin.
REQ-012 Spurious responses: `data_ok` while `!ms_valid || !wait_ok` is ignored and must not fill the buffer.
REQ-013 Combinational path: `ms_pc`, `ms_rf_waddr`, and `ms_rf_we` are registered values; `ms_rf_wdata` is combinational from the registers and rdata. Latency is one cycle plus the data_ok wait.
REQ-014 Bypass outputs:
- `ms_fwd_we = ms_valid && rf_we`.
- `ms_fwd_waddr = rf_waddr`.
- `ms_fwd_wdata = ms_rf_wdata`.
- `ms_fwd_blk = ms_valid && rf_we && load_op != 0 && !ms_ready_go`.
REQ-015 Simultaneous data_ok and capture: data_ok and new capture in the same cycle are legal when ws_allowin=1. The old instruction leaves with the live rdata, and the new wait_ok loads from es_mem_req.

Reset
REQ-016 On `reset=1` at a clock edge, the following clear to zero: ms_valid, wait_ok, buf_valid, ms_pc, alu_result, load_op, rf_waddr, rf_we, and buf_data.
- Resulting outputs: ms_to_ws_valid=0, ms_allowin=1, ms_fwd_we=0, ms_fwd_blk=0, ms_rf_we=0.
REQ-017 Reset mid-wait discards the outstanding load. A data_ok arriving after reset is ignored per REQ-012.

Configuration
REQ-018 Macro `MS_BYPASS_EN`.
- Defined: bypass outputs behave per REQ-014.
- Undefined: ms_fwd_we, ms_fwd_waddr, ms_fwd_wdata, and ms_fwd_blk are tied to 0. Ports remain present.

Verification
REQ-019 ALU op: pc=0x1c000000, alu=0x1234, rf_we=1, waddr=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, ms_rf_wdata=0x1234, ms_fwd_we=1.
REQ-020 Load-byte signed: ld.b, addr=0x...02, rdata=0x0080FF00, data_ok 2 cycles late -> ms_fwd_blk=1 for 2 cycles; then wdata=0xFFFFFF80.
REQ-021 Halfword unsigned: ld.hu, addr[1]=1, rdata=0xBEEF1234 -> wdata=0x0000BEEF.
REQ-022 Buffer fill: data_ok=1, rdata=0xA5A5A5A5, ws_allowin=0 for 3 cycles -> buf holds the data, ms_to_ws_valid=1 throughout. WB accepts 0xA5A5A5A5 once, then buf_valid=0.
REQ-023 Back-to-back: a load completes with data_ok and ws_allowin=1 while a next ALU op is captured in the same cycle -> both retire on consecutive cycles with correct data.
REQ-024 Reset mid-wait: reset during WAIT_OK, then data_ok -> ms_to_ws_valid stays 0 and buf_valid=0.
